// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Provides the fetch FSM state enum, the NOP encoding and the PC step.
package if_pkg;

    typedef enum logic [1:0] {
        REQ,
        DRAIN,
        HOLD
    } state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

endpackage

// File: rtl/pc_register.sv
// Fetch-address register with synchronous reset to RESET_PC and load enable.
// Ports: clock, reset (sync, active-high), load, d (next PC), q (current PC).
module pc_register #(
    parameter int              len      = 32,
    parameter logic [len-1:0]  RESET_PC = '0
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           load,
    input  logic [len-1:0] d,
    output logic [len-1:0] q
);

    always_ff @(posedge clock) begin
        if (reset)
            q <= RESET_PC;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, talks req/ack to imem, feeds IF/ID.
// Ports: clock, reset, freez, branch_taken, branch_address | imem_req,
// imem_addr, imem_ack, imem_rdata | pc_out, instruction_out, inst_valid, bubble.
import if_pkg::*;

module if_fetch_stage #(
    parameter int              len      = 32,
    parameter logic [len-1:0]  RESET_PC = '0
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           freez,
    input  logic           branch_taken,
    input  logic [len-1:0] branch_address,
    output logic           imem_req,
    output logic [len-1:0] imem_addr,
    input  logic           imem_ack,
    input  logic [len-1:0] imem_rdata,
    output logic [len-1:0] pc_out,
    output logic [len-1:0] instruction_out,
    output logic           inst_valid,
    output logic           bubble
);

    state_t         state;
    logic [len-1:0] pc_reg;
    logic [len-1:0] pc_inc;
    logic [len-1:0] pc_next;
    logic           pc_load;
    logic [len-1:0] redirect_pc;
    logic [len-1:0] hold_inst;

    assign pc_inc    = pc_reg + len'(PC_STEP);
    assign imem_addr = pc_reg;
    assign bubble    = !inst_valid;

    pc_register #(
        .len      (len),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clock (clock),
        .reset (reset),
        .load  (pc_load),
        .d     (pc_next),
        .q     (pc_reg)
    );

    // A response arriving in REQ is passed straight through so that a
    // single-cycle memory sustains one instruction per clock.
    always_comb begin
        pc_load         = 1'b0;
        pc_next         = pc_inc;
        imem_req        = 1'b0;
        inst_valid      = 1'b0;
        instruction_out = len'(NOP_INST);
        pc_out          = pc_inc;
        if (reset) begin
            pc_out = RESET_PC + len'(PC_STEP);
        end else begin
            unique case (state)
                REQ: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        if (branch_taken) begin
                            pc_load = 1'b1;
                            pc_next = branch_address;
                        end else begin
                            inst_valid      = 1'b1;
                            instruction_out = imem_rdata;
                            pc_load         = !freez;
                        end
                    end
                end
                DRAIN: begin
                    // Address must stay on the old PC until the stale
                    // response returns; only then jump to the target.
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        pc_load = 1'b1;
                        pc_next = branch_taken ? branch_address : redirect_pc;
                    end
                end
                HOLD: begin
                    inst_valid      = 1'b1;
                    instruction_out = hold_inst;
                    if (branch_taken) begin
                        pc_load = 1'b1;
                        pc_next = branch_address;
                    end else if (!freez) begin
                        pc_load = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= REQ;
            hold_inst   <= len'(NOP_INST);
            redirect_pc <= RESET_PC;
        end else begin
            unique case (state)
                REQ: begin
                    if (imem_ack) begin
                        if (!branch_taken && freez) begin
                            hold_inst <= imem_rdata;
                            state     <= HOLD;
                        end
                    end else if (branch_taken) begin
                        redirect_pc <= branch_address;
                        state       <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (imem_ack)
                        state <= REQ;
                    else if (branch_taken)
                        redirect_pc <= branch_address;
                end
                HOLD: begin
                    if (branch_taken || !freez)
                        state <= REQ;
                end
                default: state <= REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a scoreboard of presented
// {pc_out, instruction} pairs popped whenever IF/ID would consume.
module tb_if_fetch_stage;

    logic        clock;
    logic        reset;
    logic        freez;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        inst_valid;
    logic        bubble;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];

    if_fetch_stage #(
        .len      (32),
        .RESET_PC (32'h0)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .freez           (freez),
        .branch_taken    (branch_taken),
        .branch_address  (branch_address),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .inst_valid      (inst_valid),
        .bubble          (bubble)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sample on the falling edge; pop scoreboard on a consume.
    task automatic sample();
        logic [63:0] e;
        @(negedge clock);
        if (inst_valid === 1'b1 && !freez && !branch_taken) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk("sb_pc_out", pc_out, e[63:32]);
                chk("sb_instr", instruction_out, e[31:0]);
            end
        end
    endtask

    task automatic adv();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        freez          = 1'b0;
        branch_taken   = 1'b0;
        branch_address = '0;
        imem_ack       = 1'b0;
        imem_rdata     = '0;
        adv();
        sample();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_bubble", 32'(bubble), 32'd1);
        chk("rst_instr", instruction_out, 32'h0);
        chk("rst_pc_out", pc_out, 32'h4);
        adv();

        // 1: back-to-back fetches with imem_ack held high
        reset    = 1'b0;
        imem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            imem_rdata = 32'hA000 + 32'(i);
            sb.push_back({32'(4 * (i + 1)), imem_rdata});
            sample();
            chk("t1_addr", imem_addr, 32'(4 * i));
            chk("t1_valid", 32'(inst_valid), 32'd1);
            adv();
        end

        // 2: slow response at 0x10
        imem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sample();
            chk("t2_addr_wait", imem_addr, 32'h10);
            chk("t2_valid_wait", 32'(inst_valid), 32'd0);
            chk("t2_req_wait", 32'(imem_req), 32'd1);
            adv();
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        sb.push_back({32'h14, imem_rdata});
        sample();
        chk("t2_addr_ack", imem_addr, 32'h10);
        adv();

        // 3: freeze on the response at 0x20
        for (int i = 0; i < 3; i++) begin
            imem_rdata = 32'hB000 + 32'(i);
            sb.push_back({32'h18 + 32'(4 * i), imem_rdata});
            sample();
            adv();
        end
        freez      = 1'b1;
        imem_rdata = 32'hDEAD_0020;
        sb.push_back({32'h24, imem_rdata});
        sample();
        chk("t3_addr", imem_addr, 32'h20);
        chk("t3_valid_ack", 32'(inst_valid), 32'd1);
        adv();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        sample();
        chk("t3_hold_req", 32'(imem_req), 32'd0);
        chk("t3_hold_instr", instruction_out, 32'hDEAD_0020);
        chk("t3_hold_valid", 32'(inst_valid), 32'd1);
        adv();
        freez = 1'b0;
        sample();
        adv();
        sample();
        chk("t3_next_addr", imem_addr, 32'h24);
        chk("t3_next_req", 32'(imem_req), 32'd1);
        adv();

        // 4: branch while waiting on 0x30
        imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            imem_rdata = 32'hC000 + 32'(i);
            sb.push_back({32'h28 + 32'(4 * i), imem_rdata});
            sample();
            adv();
        end
        imem_ack       = 1'b0;
        branch_taken   = 1'b1;
        branch_address = 32'h100;
        sample();
        chk("t4_addr_br", imem_addr, 32'h30);
        adv();
        branch_taken = 1'b0;
        sample();
        chk("t4_addr_drain", imem_addr, 32'h30);
        chk("t4_valid_drain", 32'(inst_valid), 32'd0);
        adv();
        imem_ack   = 1'b1;
        imem_rdata = 32'h0BAD_0030;
        sample();
        chk("t4_addr_ack", imem_addr, 32'h30);
        chk("t4_discard", 32'(inst_valid), 32'd0);
        adv();
        imem_ack = 1'b0;
        sample();
        chk("t4_target", imem_addr, 32'h100);
        adv();

        // 5: branch coincident with ack and freez
        imem_ack       = 1'b1;
        freez          = 1'b1;
        branch_taken   = 1'b1;
        branch_address = 32'h80;
        imem_rdata     = 32'h0BAD_0100;
        sample();
        adv();
        imem_ack     = 1'b0;
        freez        = 1'b0;
        branch_taken = 1'b0;
        sample();
        chk("t5_no_hold", 32'(imem_req), 32'd1);
        chk("t5_target", imem_addr, 32'h80);
        chk("t5_valid", 32'(inst_valid), 32'd0);
        adv();

        // 6: reset in DRAIN, then PC wrap
        branch_taken   = 1'b1;
        branch_address = 32'h200;
        sample();
        adv();
        branch_taken = 1'b0;
        reset        = 1'b1;
        sample();
        chk("t6_rst_req", 32'(imem_req), 32'd0);
        chk("t6_rst_pc_out", pc_out, 32'h4);
        adv();
        reset = 1'b0;
        sample();
        chk("t6_after_rst", imem_addr, 32'h0);
        chk("t6_req", 32'(imem_req), 32'd1);
        adv();
        imem_ack       = 1'b1;
        branch_taken   = 1'b1;
        branch_address = 32'hFFFF_FFFC;
        imem_rdata     = 32'h0BAD_0000;
        sample();
        adv();
        branch_taken = 1'b0;
        imem_rdata   = 32'h0000_0013;
        sb.push_back({32'h0, imem_rdata});
        sample();
        chk("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
        adv();
        imem_ack = 1'b0;
        sample();
        chk("t6_wrap", imem_addr, 32'h0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
